// File: rtl/push_btn_array.sv
// push_btn_array: up to 8 debounced push buttons behind a 12-bit instruction port.
// Per-channel sticky press/release latches, an event mask and debounced-level read-back.
//
// state    | meaning
// ---------|-------------------------------------------------------------
// ST_RESET | first cycle out of reset, instructions ignored
// ST_READY | latching masked events and executing instructions
// ST_ERROR | undefined opcode seen; outputs forced, sticky until reset
module push_btn_array #(
  parameter int Channels     = 4,
  parameter int DebounceWait = 40000,
  parameter int DebounceSize = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [11:0]         inst,
  input  logic                inst_en,
  input  logic [Channels-1:0] buttons,
  output logic [Channels-1:0] button_status,
  output logic                error
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_RDPR = 4'h1;
  localparam logic [3:0] OP_RDRL = 4'h2;
  localparam logic [3:0] OP_RDLV = 4'h3;
  localparam logic [3:0] OP_WRMK = 4'h4;
  localparam logic [3:0] OP_CLR  = 4'h5;

  localparam logic [DebounceSize-1:0] CntLast = DebounceSize'(DebounceWait - 1);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_READY = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t state;

  logic [Channels-1:0]     sync_a;
  logic [Channels-1:0]     sync_b;
  logic [Channels-1:0]     db;
  logic [Channels-1:0]     db_d;
  logic [DebounceSize-1:0] cnt [Channels];

  logic [Channels-1:0] mask;
  logic [Channels-1:0] press_l;
  logic [Channels-1:0] release_l;

  logic [Channels-1:0] press_evt;
  logic [Channels-1:0] release_evt;
  logic [Channels-1:0] press_new;
  logic [Channels-1:0] release_new;

  // Immediate bits above Channels are don't-care for narrower arrays.
  logic unused_imm_bits;
  assign unused_imm_bits = ^inst[7:0];

  // Edge pulses of the debounced level, gated by the mask as it stood this cycle.
  assign press_evt   = db & ~db_d;
  assign release_evt = ~db & db_d;
  assign press_new   = press_evt & mask;
  assign release_new = release_evt & mask;

  // Synchronise raw inputs and debounce each channel; runs regardless of FSM state.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
      db     <= '0;
      db_d   <= '0;
      for (int i = 0; i < Channels; i++) cnt[i] <= '0;
    end else begin
      sync_a <= buttons;
      sync_b <= sync_a;
      db_d   <= db;
      for (int i = 0; i < Channels; i++) begin
        if (sync_b[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CntLast) begin
          db[i]  <= ~db[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + DebounceSize'(1);
        end
      end
    end
  end

  // Control FSM: event latching, instruction decode and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_RESET;
      button_status <= '0;
      error         <= 1'b0;
      mask          <= '1;
      press_l       <= '0;
      release_l     <= '0;
    end else begin
      case (state)
        ST_RESET: begin
          state <= ST_READY;
          error <= 1'b0;
        end
        ST_READY: begin
          error     <= 1'b0;
          press_l   <= press_l | press_new;
          release_l <= release_l | release_new;
          if (inst_en) begin
            case (inst[11:8])
              OP_NOP: ;
              OP_RDPR: begin
                // Read-and-clear, but keep an event landing in this very cycle.
                button_status <= press_l;
                press_l       <= press_new;
              end
              OP_RDRL: begin
                button_status <= release_l;
                release_l     <= release_new;
              end
              OP_RDLV: button_status <= db;
              OP_WRMK: mask <= inst[Channels-1:0];
              OP_CLR: begin
                button_status <= '0;
                press_l       <= '0;
                release_l     <= '0;
              end
              default: begin
                state         <= ST_ERROR;
                error         <= 1'b1;
                button_status <= '0;
                press_l       <= '0;
                release_l     <= '0;
              end
            endcase
          end
        end
        default: begin
          // ST_ERROR and any illegal encoding settle in the error state.
          state         <= ST_ERROR;
          error         <= 1'b1;
          button_status <= '0;
          press_l       <= '0;
          release_l     <= '0;
        end
      endcase
    end
  end

endmodule
